// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback arbiter for the register file's single write port.
// Stages the winning write for one cycle and exports a pending-write bitmap for hazard stalls.
module regfile_wb_arbiter #(
  parameter int N_REQ = 3,
  parameter int PTR_W = $clog2(N_REQ)
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [N_REQ-1:0]     i_req_valid,
  input  logic [5*N_REQ-1:0]   i_req_addr,
  input  logic [32*N_REQ-1:0]  i_req_data,
  output logic [N_REQ-1:0]     o_req_ready,
  output logic                 o_rd_wren,
  output logic [4:0]           o_rd_addr,
  output logic [31:0]          o_rd_data,
  output logic [PTR_W-1:0]     o_grant_id,
  output logic [31:0]          o_pending_mask
);

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] gid_q, gid_d;
  logic             wren_q, wren_d;
  logic [4:0]       addr_q, addr_d;
  logic [31:0]      data_q, data_d;

  logic [N_REQ-1:0] grant_oh;
  logic             found;
  logic [PTR_W-1:0] grant_idx;
  logic [4:0]       win_addr;
  logic [31:0]      win_data;
  int               idx;

  // Search order is ptr, ptr+1, ... wrapping; compares against constant k keep all selects static.
  always_comb begin
    grant_oh  = '0;
    found     = 1'b0;
    grant_idx = '0;
    win_addr  = '0;
    win_data  = '0;
    idx       = 0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      for (int k = 0; k < N_REQ; k++) begin
        if (!found && (k == idx) && i_req_valid[k]) begin
          found       = 1'b1;
          grant_oh[k] = 1'b1;
          grant_idx   = PTR_W'(k);
          win_addr    = i_req_addr[k*5 +: 5];
          win_data    = i_req_data[k*32 +: 32];
        end
      end
    end
  end

  always_comb begin
    ptr_d  = ptr_q;
    gid_d  = gid_q;
    addr_d = addr_q;
    data_d = data_q;
    wren_d = 1'b0;
    if (found) begin
      ptr_d  = (grant_idx == PTR_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
      gid_d  = grant_idx;
      addr_d = win_addr;
      data_d = win_data;
      // x0 writes complete the handshake but never reach the regfile.
      wren_d = (win_addr != 5'd0);
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      ptr_q  <= '0;
      gid_q  <= '0;
      wren_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      ptr_q  <= ptr_d;
      gid_q  <= gid_d;
      wren_q <= wren_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  always_comb begin
    o_pending_mask = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (i_req_valid[k]) o_pending_mask[i_req_addr[k*5 +: 5]] = 1'b1;
    end
    if (wren_q) o_pending_mask[addr_q] = 1'b1;
    o_pending_mask[0] = 1'b0;
  end

  assign o_req_ready = i_reset ? grant_oh : '0;
  assign o_rd_wren   = wren_q;
  assign o_rd_addr   = addr_q;
  assign o_rd_data   = data_q;
  assign o_grant_id  = gid_q;

endmodule
